throw_ctl: RTL and testbench

Turn-based projectile sequencer for the cat-vs-dog scene. It accepts a fire request from the active player and advances the projectile once per video frame, using signed kinematics with gravity. It detects collision with the fence, the ground, the opponent and the screen edges, holds the impact result for a fixed number of frames, then passes the turn to the other player. Its outputs feed the projectile and sprite draw stages that sit downstream of draw_background in the vga_if chain.

---
 rtl/variable_pkg.sv | 20 ++
 rtl/frame_tick.sv | 22 ++
 rtl/throw_ctl.sv | 166 ++++++++++++++++
 tb/tb_throw_ctl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Scene constants and state type shared by the cat-vs-dog movers.
// FENCE_*  : fence rectangle (x span and top edge), inclusive bounds
// GROUND_Y : ground line; a projectile at or below it has landed
// HMAX     : rightmost visible column
// throw_state_t : projectile sequencer states
package variable_pkg;

  localparam logic signed [12:0] FENCE_X0 = 13'sd497;
  localparam logic signed [12:0] FENCE_X1 = 13'sd527;
  localparam logic signed [12:0] FENCE_Y0 = 13'sd384;
  localparam logic signed [12:0] GROUND_Y = 13'sd668;
  localparam logic signed [12:0] HMAX     = 13'sd1023;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    IMPACT = 2'd2
  } throw_state_t;

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector on vblnk; produces a one-clock frame tick.
// clk_i   : system clock
// rst_i   : asynchronous active-high reset
// vblnk_i : vertical blank from the timing chain
// tick_o  : high for one clock after vblnk rises
module frame_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vblnk_i,
  output logic tick_o
);

  logic vblnk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vblnk_q <= 1'b0;
    else       vblnk_q <= vblnk_i;
  end

  assign tick_o = vblnk_i & ~vblnk_q;

endmodule

// File: rtl/throw_ctl.sv
// Turn-based projectile sequencer for the cat-vs-dog scene.
// Launches on fire, moves the projectile once per frame with gravity,
// detects fence / ground / screen-edge contact, holds the result for
// IMPACT_FRAMES frames and then hands the turn to the other player.
// clk60MHz     : system clock
// rst          : asynchronous active-high reset (aborts any shot)
// vblnk        : vertical blank; rising edge = frame tick
// fire, power  : launch request and strength 0..15
// turn         : 0 cat to play, 1 dog to play
// busy         : shot in FLIGHT or IMPACT
// proj_visible : projectile drawn (FLIGHT only)
// proj_x/y     : projectile position, never negative
// hit_fence    : last shot struck the fence
// hit_target   : last shot landed on the opponent
module throw_ctl
  import variable_pkg::*;
#(
  parameter int CAT_X         = 264,
  parameter int DOG_X         = 760,
  parameter int LAUNCH_Y      = 600,
  parameter int GRAVITY       = 1,
  parameter int TARGET_W      = 64,
  parameter int IMPACT_FRAMES = 30
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        fire,
  input  logic [3:0]  power,
  output logic        turn,
  output logic        busy,
  output logic        proj_visible,
  output logic [11:0] proj_x,
  output logic [11:0] proj_y,
  output logic        hit_fence,
  output logic        hit_target
);

  localparam logic signed [12:0] CAT13 = 13'(CAT_X);
  localparam logic signed [12:0] DOG13 = 13'(DOG_X);
  localparam logic signed [12:0] LY13  = 13'(LAUNCH_Y);
  localparam logic signed [12:0] G13   = 13'(GRAVITY);
  localparam logic signed [12:0] TW13  = 13'(TARGET_W);
  localparam logic [4:0]         CNT_LAST = 5'(IMPACT_FRAMES - 1);

  logic tick;

  frame_tick u_frame_tick (
    .clk_i   (clk60MHz),
    .rst_i   (rst),
    .vblnk_i (vblnk),
    .tick_o  (tick)
  );

  throw_state_t      state_q;
  logic              turn_q, busy_q, vis_q, hf_q, ht_q;
  logic signed [12:0] x_q, y_q, vx_q, vy_q;
  logic [4:0]        cnt_q;

  // Launch values derived from the current turn and power.
  logic [3:0]         mag;
  logic [4:0]         spd;
  logic signed [12:0] mag_s, vx0, vy0, launch_x, opp_x;
  assign mag      = 4'd4 + {1'b0, power[3:1]};
  assign spd      = 5'd8 + {1'b0, power};
  assign mag_s    = $signed({9'd0, mag});
  assign vx0      = turn_q ? -mag_s : mag_s;
  assign vy0      = -$signed({8'd0, spd});
  assign launch_x = turn_q ? DOG13 : CAT13;
  assign opp_x    = turn_q ? CAT13 : DOG13;

  // Candidate position for this frame; collisions are judged on it.
  logic signed [12:0] nx_d, ny_d, dx, adx;
  logic               fence_c, ground_c, off_c, on_target;
  assign nx_d      = x_q + vx_q;
  assign ny_d      = y_q + vy_q;
  assign dx        = nx_d - opp_x;
  assign adx       = dx[12] ? -dx : dx;
  assign on_target = adx <= TW13;
  assign fence_c   = (nx_d >= FENCE_X0) && (nx_d <= FENCE_X1) && (ny_d >= FENCE_Y0);
  assign ground_c  = ny_d >= GROUND_Y;
  assign off_c     = (nx_d < 13'sd0) || (nx_d > HMAX);

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      turn_q  <= 1'b0;
      busy_q  <= 1'b0;
      vis_q   <= 1'b0;
      hf_q    <= 1'b0;
      ht_q    <= 1'b0;
      x_q     <= CAT13;
      y_q     <= LY13;
      vx_q    <= '0;
      vy_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // x_q/y_q already sit at the launch point of the current turn.
          if (fire) begin
            x_q     <= launch_x;
            y_q     <= LY13;
            vx_q    <= vx0;
            vy_q    <= vy0;
            hf_q    <= 1'b0;
            ht_q    <= 1'b0;
            busy_q  <= 1'b1;
            vis_q   <= 1'b1;
            state_q <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (tick) begin
            vy_q <= vy_q + G13;
            x_q  <= nx_d;
            y_q  <= ny_d;
            if (fence_c) begin
              hf_q    <= 1'b1;
              vis_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= IMPACT;
            end else if (ground_c) begin
              y_q     <= GROUND_Y;
              ht_q    <= on_target;
              vis_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= IMPACT;
            end else if (off_c) begin
              x_q     <= nx_d[12] ? 13'sd0 : HMAX;
              vis_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= IMPACT;
            end
          end
        end
        IMPACT: begin
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              turn_q  <= ~turn_q;
              busy_q  <= 1'b0;
              // Park at the incoming player's launch point.
              x_q     <= turn_q ? CAT13 : DOG13;
              y_q     <= LY13;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign turn         = turn_q;
  assign busy         = busy_q;
  assign proj_visible = vis_q;
  assign hit_fence    = hf_q;
  assign hit_target   = ht_q;
  // Saturate at zero so the port never shows a wrapped negative.
  assign proj_x       = x_q[12] ? 12'd0 : x_q[11:0];
  assign proj_y       = y_q[12] ? 12'd0 : y_q[11:0];

endmodule

// File: tb/tb_throw_ctl.sv
module tb_throw_ctl;

  localparam int CAT_X = 264;
  localparam int DOG_X = 760;
  localparam int LY    = 600;

  logic        clk60MHz = 1'b0;
  logic        rst, vblnk, fire;
  logic [3:0]  power;
  logic        turn, busy, proj_visible, hit_fence, hit_target;
  logic [11:0] proj_x, proj_y;

  int errors = 0;
  int checks = 0;
  bit exp_turn = 1'b0;

  throw_ctl dut (
    .clk60MHz     (clk60MHz),
    .rst          (rst),
    .vblnk        (vblnk),
    .fire         (fire),
    .power        (power),
    .turn         (turn),
    .busy         (busy),
    .proj_visible (proj_visible),
    .proj_x       (proj_x),
    .proj_y       (proj_y),
    .hit_fence    (hit_fence),
    .hit_target   (hit_target)
  );

  always #8 clk60MHz = ~clk60MHz;

  task automatic cyc();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic do_tick();
    vblnk = 1'b1;
    cyc();
    vblnk = 1'b0;
    cyc();
  endtask

  // Closed-form trajectory: x linear in n, y quadratic (gravity 1 per frame).
  function automatic int mx(bit t, int p, int n);
    int mag;
    mag = 4 + p / 2;
    return t ? DOG_X - mag * n : CAT_X + mag * n;
  endfunction

  function automatic int my(int p, int n);
    return LY - (8 + p) * n + (n * (n - 1)) / 2;
  endfunction

  task automatic model_shot(input bit t, input int p, output int n_o, output int x_o,
                            output int y_o, output bit hf_o, output bit ht_o);
    bit done;
    int x, y, d;
    done = 0; n_o = 0; x_o = 0; y_o = 0; hf_o = 0; ht_o = 0;
    for (int n = 1; n <= 300 && !done; n++) begin
      x = mx(t, p, n);
      y = my(p, n);
      if (x >= 497 && x <= 527 && y >= 384) begin
        done = 1; n_o = n; x_o = x; y_o = y; hf_o = 1;
      end else if (y >= 668) begin
        done = 1; n_o = n; x_o = x; y_o = 668;
        d = x - (t ? CAT_X : DOG_X);
        if (d < 0) d = -d;
        ht_o = (d <= 64);
      end else if (x < 0 || x > 1023) begin
        done = 1; n_o = n; x_o = (x < 0) ? 0 : 1023; y_o = y;
      end
    end
  endtask

  // Full shot from IDLE through IMPACT back to IDLE, checked against the model.
  task automatic run_shot(input int p, input bit ign, input bit sim, output int dn,
                          output int dx, output int dy, output bit dhf, output bit dht);
    int mn, mxv, myv, lx, nlx;
    bit mhf, mht, t;
    t   = exp_turn;
    lx  = t ? DOG_X : CAT_X;
    nlx = t ? CAT_X : DOG_X;
    model_shot(t, p, mn, mxv, myv, mhf, mht);
    power = 4'(p);
    if (sim) begin
      vblnk = 1'b1; fire = 1'b1;
      cyc();
      vblnk = 1'b0; fire = 1'b0;
      cyc();
    end else begin
      fire = 1'b1;
      cyc();
      fire = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || proj_visible !== 1'b1 || proj_x !== 12'(lx) || proj_y !== 12'(LY) ||
        hit_fence !== 1'b0 || hit_target !== 1'b0) begin
      errors++;
      $display("FAIL launch p=%0d: busy=%0b vis=%0b x=%0d y=%0d hf=%0b ht=%0b, want 1 1 %0d %0d 0 0",
               p, busy, proj_visible, proj_x, proj_y, hit_fence, hit_target, lx, LY);
    end
    dn = 0;
    for (int n = 1; n <= 300 && dn == 0; n++) begin
      if (ign && n == 3) begin
        power = ~4'(p); fire = 1'b1;
        cyc();
        fire = 1'b0; power = 4'(p);
      end
      do_tick();
      if (proj_visible !== 1'b1) dn = n;
      else if (n < mn) begin
        checks++;
        if (busy !== 1'b1 || proj_x !== 12'(mx(t, p, n)) || proj_y !== 12'(my(p, n))) begin
          errors++;
          $display("FAIL flight p=%0d tick %0d: busy=%0b x=%0d y=%0d, want 1 %0d %0d",
                   p, n, busy, proj_x, proj_y, mx(t, p, n), my(p, n));
        end
      end
    end
    checks++;
    if (dn !== mn) begin
      errors++;
      $display("FAIL impact_tick p=%0d: got %0d want %0d", p, dn, mn);
    end
    dx = int'(proj_x); dy = int'(proj_y); dhf = hit_fence; dht = hit_target;
    checks++;
    if (busy !== 1'b1 || proj_x !== 12'(mxv) || proj_y !== 12'(myv) ||
        hit_fence !== mhf || hit_target !== mht) begin
      errors++;
      $display("FAIL impact p=%0d: busy=%0b x=%0d y=%0d hf=%0b ht=%0b, want 1 %0d %0d %0b %0b",
               p, busy, proj_x, proj_y, hit_fence, hit_target, mxv, myv, mhf, mht);
    end
    for (int k = 1; k <= 30; k++) begin
      if (ign && k == 2) begin
        fire = 1'b1;
        cyc();
        fire = 1'b0;
      end
      do_tick();
      if (k < 30) begin
        checks++;
        if (busy !== 1'b1 || proj_visible !== 1'b0 || turn !== t || proj_x !== 12'(mxv) ||
            hit_fence !== mhf || hit_target !== mht) begin
          errors++;
          $display("FAIL hold k=%0d: busy=%0b vis=%0b turn=%0b x=%0d hf=%0b ht=%0b, want 1 0 %0b %0d %0b %0b",
                   k, busy, proj_visible, turn, proj_x, hit_fence, hit_target, t, mxv, mhf, mht);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || proj_visible !== 1'b0 || turn !== ~t || proj_x !== 12'(nlx) ||
        proj_y !== 12'(LY) || hit_fence !== mhf || hit_target !== mht) begin
      errors++;
      $display("FAIL handover: busy=%0b vis=%0b turn=%0b x=%0d y=%0d hf=%0b ht=%0b, want 0 0 %0b %0d %0d %0b %0b",
               busy, proj_visible, turn, proj_x, proj_y, hit_fence, hit_target, ~t, nlx, LY, mhf, mht);
    end
    exp_turn = ~t;
  endtask

  task automatic check_idle_reset(input string tag);
    checks++;
    if (turn !== 1'b0 || busy !== 1'b0 || proj_visible !== 1'b0 || proj_x !== 12'(CAT_X) ||
        proj_y !== 12'(LY) || hit_fence !== 1'b0 || hit_target !== 1'b0) begin
      errors++;
      $display("FAIL %s: turn=%0b busy=%0b vis=%0b x=%0d y=%0d hf=%0b ht=%0b, want 0 0 0 264 600 0 0",
               tag, turn, busy, proj_visible, proj_x, proj_y, hit_fence, hit_target);
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    check_idle_reset("async_reset");
    cyc();
    rst = 1'b0;
    cyc();
    check_idle_reset("after_reset");
    exp_turn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk = 1'b0; fire = 1'b0; power = 4'd0;
    repeat (3) cyc();
    check_idle_reset("reset_hold");
    rst = 1'b0;
    cyc();
    check_idle_reset("reset_release");
  endtask

  task automatic test_launch();
    power = 4'd0; fire = 1'b1;
    cyc();
    fire = 1'b0;
    do_tick();
    checks++;
    if (proj_x !== 12'd268 || proj_y !== 12'd592 || proj_visible !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: x=%0d y=%0d vis=%0b, want 268 592 1", proj_x, proj_y, proj_visible);
    end
    do_tick();
    checks++;
    if (proj_x !== 12'd272 || proj_y !== 12'd585) begin
      errors++;
      $display("FAIL second_tick: x=%0d y=%0d, want 272 585", proj_x, proj_y);
    end
    async_reset();
  endtask

  task automatic test_ground_miss();
    int n, x, y; bit hf, ht;
    run_shot(0, 0, 0, n, x, y, hf, ht);
    checks++;
    if (n !== 23 || x !== 356 || y !== 668 || hf !== 1'b0 || ht !== 1'b0) begin
      errors++;
      $display("FAIL ground_miss: tick=%0d x=%0d y=%0d hf=%0b ht=%0b, want 23 356 668 0 0", n, x, y, hf, ht);
    end
  endtask

  task automatic test_reset_mid_dog();
    power = 4'd7; fire = 1'b1;
    cyc();
    fire = 1'b0;
    repeat (5) do_tick();
    checks++;
    if (turn !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dog_in_flight: turn=%0b busy=%0b, want 1 1", turn, busy);
    end
    async_reset();
  endtask

  task automatic test_fence();
    int n, x, y; bit hf, ht;
    run_shot(8, 0, 0, n, x, y, hf, ht);
    checks++;
    if (n !== 30 || x !== 504 || y !== 555 || hf !== 1'b1 || ht !== 1'b0) begin
      errors++;
      $display("FAIL fence: tick=%0d x=%0d y=%0d hf=%0b ht=%0b, want 30 504 555 1 0", n, x, y, hf, ht);
    end
  endtask

  task automatic test_target();
    int n, x, y; bit hf, ht;
    run_shot(15, 0, 0, n, x, y, hf, ht);
    checks++;
    if (n !== 50 || x !== 814 || y !== 668 || hf !== 1'b0 || ht !== 1'b1) begin
      errors++;
      $display("FAIL target: tick=%0d x=%0d y=%0d hf=%0b ht=%0b, want 50 814 668 0 1", n, x, y, hf, ht);
    end
  endtask

  task automatic test_mirror();
    int n, x, y; bit hf, ht;
    run_shot(15, 0, 0, n, x, y, hf, ht);
    checks++;
    if (n !== 50 || x !== 210 || y !== 668 || hf !== 1'b0 || ht !== 1'b1) begin
      errors++;
      $display("FAIL mirror: tick=%0d x=%0d y=%0d hf=%0b ht=%0b, want 50 210 668 0 1", n, x, y, hf, ht);
    end
  endtask

  task automatic test_ignore_fire();
    int n, x, y; bit hf, ht;
    run_shot(int'($urandom_range(0, 15)), 1, 0, n, x, y, hf, ht);
  endtask

  task automatic test_fire_with_tick();
    int n, x, y; bit hf, ht;
    run_shot(int'($urandom_range(0, 15)), 0, 1, n, x, y, hf, ht);
  endtask

  task automatic test_random();
    int n, x, y; bit hf, ht;
    for (int i = 0; i < 6; i++)
      run_shot(int'($urandom_range(0, 15)), i[0], 0, n, x, y, hf, ht);
  endtask

  initial begin
    test_reset();
    test_launch();
    test_ground_miss();
    test_reset_mid_dog();
    test_fence();
    test_mirror();
    test_target();
    test_ignore_fire();
    test_fire_with_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
